// File: rtl/imem_loader_if.sv
// Handshake bundle between a byte-stream/control master and the instruction-memory loader.
interface imem_loader_if #(
  parameter int IDX_W = 7
);
  logic             start;
  logic [IDX_W-1:0] base_word;
  logic [IDX_W-1:0] word_count;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, base_word, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );

  modport slave (
    input  start, base_word, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to a
// range-checked window of the instruction memory.
module imem_loader #(
  parameter int DEPTH = 101,
  parameter int IDX_W = 7
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_e;

  state_e           state_q;
  logic [1:0]       bcnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] rem_q;
  logic [23:0]      word_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             error_q;

  logic [IDX_W:0]   end_d;
  logic             range_bad_d;
  logic [31:0]      word_d;

  // End of the requested window, one bit wider so base+count cannot wrap.
  assign end_d       = {1'b0, bus.base_word} + {1'b0, bus.word_count};
  assign range_bad_d = end_d > (IDX_W+1)'(DEPTH);
  assign word_d      = {word_q, bus.in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            idx_q   <= bus.base_word;
            rem_q   <= bus.word_count;
            bcnt_q  <= '0;
            error_q <= range_bad_d;
            state_q <= (bus.word_count == '0 || range_bad_d) ? FINISH : COLLECT;
          end
        end
        COLLECT: begin
          if (bus.in_valid) begin
            word_q <= word_d[23:0];
            bcnt_q <= bcnt_q + 2'd1;
            // Address/data are staged here so they present during WRITE and hold afterwards.
            if (bcnt_q == 2'd3) begin
              addr_q  <= {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
              wdata_q <= word_d;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          idx_q   <= idx_q + 1'b1;
          rem_q   <= rem_q - 1'b1;
          state_q <= (rem_q == IDX_W'(1)) ? FINISH : COLLECT;
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);
  assign bus.error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench: drivers queue expected writes/done pulses, a negedge monitor checks them.
module tb_imem_loader;
  localparam int IDX_W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.IDX_W(IDX_W)) bus ();
  imem_loader #(.DEPTH(101), .IDX_W(IDX_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_we = -100;
  int  done_seen = 0;
  int  exp_done = 0;
  bit  rdy_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DUT write and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    int  d;
    cyc++;
    if (bus.in_ready === 1'b1) rdy_seen = 1'b1;
    if (bus.mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h at cycle %0d", bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", bus.mem_addr, e.addr);
        chk("wr_data", bus.mem_wdata, e.data);
        if (e.at >= 0) chk("wr_cycle", cyc, e.at);
      end
      last_we = cyc;
    end
    if (bus.done === 1'b1) begin
      done_seen++;
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: at cycle %0d", cyc);
      end else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, (d < 0) ? last_we + 1 : d);
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int at);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.at   = at;
    wr_q.push_back(e);
  endtask

  // Called at posedge+1; k is the monitor cycle that first sees start high.
  task automatic do_start(input int base, input int count, output int k);
    bus.start      = 1'b1;
    bus.base_word  = IDX_W'(base);
    bus.word_count = IDX_W'(count);
    k = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready %b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (toggle) begin
      bus.start      = 1'b1;
      bus.base_word  = '0;
      bus.word_count = IDX_W'(1);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], toggle);
  endtask

  task automatic wait_done();
    int n = 0;
    exp_done++;
    while (done_seen < exp_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_seen < exp_done) begin
      errors++;
      $display("FAIL done_timeout: seen %0d required %0d", done_seen, exp_done);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bus.start      = 1'b0;
    bus.base_word  = '0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two words, continuous stream: 5-cycle word cadence, done right after last write.
    do_start(0, 2, k);
    push_wr(32'h0, 32'h3C100000, k + 5);
    push_wr(32'h4, 32'h36100000, k + 10);
    done_q.push_back(k + 11);
    send_word(32'h3C100000, 1'b0);
    send_word(32'h36100000, 1'b0);
    wait_done();
    chk("t1_error", 32'(bus.error), 32'd0);
    chk("t1_addr_hold", bus.mem_addr, 32'h4);
    chk("t1_data_hold", bus.mem_wdata, 32'h36100000);
    chk("t1_busy_idle", 32'(bus.busy), 32'd0);

    // Last valid word index.
    do_start(100, 1, k);
    push_wr(32'h190, 32'h0000000C, k + 5);
    done_q.push_back(k + 6);
    send_word(32'h0000000C, 1'b0);
    wait_done();
    chk("t2_error", 32'(bus.error), 32'd0);

    // Window past the end: no writes, no ready, sticky error.
    rdy_seen = 1'b0;
    do_start(99, 3, k);
    done_q.push_back(k + 1);
    wait_done();
    chk("t3_error", 32'(bus.error), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_error_sticky", 32'(bus.error), 32'd1);
    chk("t3_no_ready", 32'(rdy_seen), 32'd0);
    chk("t3_busy_idle", 32'(bus.busy), 32'd0);

    // Zero-length load clears error and finishes at once.
    do_start(0, 0, k);
    done_q.push_back(k + 1);
    chk("t4_error_cleared", 32'(bus.error), 32'd0);
    wait_done();
    chk("t4_error", 32'(bus.error), 32'd0);

    // Gappy stream with start pulses while busy.
    do_start(0, 2, k);
    push_wr(32'h0, 32'h3C100000, -1);
    push_wr(32'h4, 32'h36100000, -1);
    done_q.push_back(-1);
    send_word(32'h3C100000, 1'b1);
    send_word(32'h36100000, 1'b1);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_idle", 32'(bus.busy), 32'd0);
    chk("t5_wr_q_empty", wr_q.size(), 32'd0);
    chk("t5_error", 32'(bus.error), 32'd0);

    // Reset mid-word abandons the partial word.
    do_start(3, 1, k);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(5, 1, k);
    push_wr(32'h14, 32'h20080000, k + 5);
    done_q.push_back(k + 6);
    send_word(32'h20080000, 1'b0);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_wr_q_empty", wr_q.size(), 32'd0);
    chk("t6_done_q_empty", done_q.size(), 32'd0);
    chk("t6_error", 32'(bus.error), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
